// File: rtl/phase_to_sine_pkg.sv
// Shared constants, quadrant encoding and the quarter-wave table generator
// used both to fill the sine ROM and as the bench's golden reference.
package phase_to_sine_pkg;

    localparam int PHASE_WIDTH = 32;
    localparam int ADDR_BITS   = 8;
    localparam int DATA_WIDTH  = 16;
    localparam int ROM_DEPTH   = 1 << ADDR_BITS;
    localparam int AMP         = (1 << (DATA_WIDTH - 1)) - 1;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        QUAD_0 = 2'b00,
        QUAD_1 = 2'b01,
        QUAD_2 = 2'b10,
        QUAD_3 = 2'b11
    } quadrant_t;

    // Taylor series, only ever evaluated on [0, pi/2]; 12 terms is far below 1 LSB.
    function automatic real sine_series(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Half-LSB phase offset keeps the table symmetric under address mirroring.
    function automatic logic [DATA_WIDTH-2:0] rom_entry(input int k);
        real angle;
        angle = 2.0 * PI * (real'(k) + 0.5) / (4.0 * real'(ROM_DEPTH));
        return (DATA_WIDTH - 1)'($rtoi(real'(AMP) * sine_series(angle) + 0.5));
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine magnitude table with a registered, enable-gated read port.
module sine_quarter_rom
    import phase_to_sine_pkg::*;
(
    input  logic                  CLK,
    input  logic                  en,
    input  logic [ADDR_BITS-1:0]  addr,
    output logic [DATA_WIDTH-2:0] data
);

    logic [DATA_WIDTH-2:0] rom_table [ROM_DEPTH];
    logic [DATA_WIDTH-2:0] data_reg;

    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
        localparam logic [DATA_WIDTH-2:0] ENTRY = rom_entry(gi);
        assign rom_table[gi] = ENTRY;
    end

    // Read register holds under backpressure so the pipeline slot is not lost.
    always_ff @(posedge CLK) begin
        if (en) begin
            data_reg <= rom_table[addr];
        end
    end

    assign data = data_reg;

endmodule

// File: rtl/phase_to_sine.sv
// Three-stage phase-to-amplitude converter: fold address, quarter-wave ROM
// lookup, conditional negate; valid/ready on both sides with full-pipeline stall.
module phase_to_sine
    import phase_to_sine_pkg::*;
(
    input  logic                   CLK,
    input  logic                   SCLR,
    input  logic [PHASE_WIDTH-1:0] phase_in,
    input  logic                   phase_valid,
    output logic                   phase_ready,
    output logic [DATA_WIDTH-1:0]  sample_out,
    output logic                   sample_valid,
    input  logic                   sample_ready
);

    quadrant_t             quad;
    logic [ADDR_BITS-1:0]  raw_addr;
    logic                  mirror;
    logic                  negate;
    logic                  advance;
    logic                  unused_lsbs;

    logic                  s1_valid_reg;
    logic                  s1_sign_reg;
    logic [ADDR_BITS-1:0]  s1_addr_reg;
    logic                  s2_valid_reg;
    logic                  s2_sign_reg;
    logic [DATA_WIDTH-2:0] rom_data;
    logic [DATA_WIDTH-1:0] magnitude;
    logic [DATA_WIDTH-1:0] sample_next;
    logic [DATA_WIDTH-1:0] sample_out_reg;
    logic                  sample_valid_reg;

    assign quad        = quadrant_t'(phase_in[PHASE_WIDTH-1 -: 2]);
    assign raw_addr    = phase_in[PHASE_WIDTH-3 -: ADDR_BITS];
    assign unused_lsbs = ^phase_in[PHASE_WIDTH-3-ADDR_BITS:0];
    assign mirror      = (quad == QUAD_1) || (quad == QUAD_3);
    assign negate      = (quad == QUAD_2) || (quad == QUAD_3);

    // Whole pipeline moves as one unit; it may move whenever the output slot frees up.
    assign advance     = !sample_valid_reg || sample_ready;
    assign phase_ready = advance;

    sine_quarter_rom u_rom (
        .CLK  (CLK),
        .en   (advance),
        .addr (s1_addr_reg),
        .data (rom_data)
    );

    assign magnitude   = {1'b0, rom_data};
    assign sample_next = s2_sign_reg ? -magnitude : magnitude;

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            s1_valid_reg     <= 1'b0;
            s2_valid_reg     <= 1'b0;
            sample_valid_reg <= 1'b0;
            sample_out_reg   <= '0;
        end else if (advance) begin
            s1_valid_reg     <= phase_valid;
            s2_valid_reg     <= s1_valid_reg;
            sample_valid_reg <= s2_valid_reg;
            sample_out_reg   <= sample_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (advance) begin
            s1_sign_reg <= negate;
            s1_addr_reg <= mirror ? ~raw_addr : raw_addr;
            s2_sign_reg <= s1_sign_reg;
        end
    end

    assign sample_out   = sample_out_reg;
    assign sample_valid = sample_valid_reg;

endmodule

// File: tb/tb_phase_to_sine.sv
// Directed bench for phase_to_sine: corners, mirroring, truncation, stalls,
// bubbles, mid-stream reset and a full-turn sweep against the table function.
module tb_phase_to_sine;
    import phase_to_sine_pkg::*;

    localparam int LOG_LEN = 4096;

    logic                   CLK = 1'b0;
    logic                   SCLR;
    logic [PHASE_WIDTH-1:0] phase_in;
    logic                   phase_valid;
    logic                   phase_ready;
    logic [DATA_WIDTH-1:0]  sample_out;
    logic                   sample_valid;
    logic                   sample_ready;

    typedef struct {
        longint val;
        int     due;
        bit     lat;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_checks = 0;
    int     n_fail = 0;
    int     cycle = 0;
    int     last_accept = 0;
    bit     sv_log [LOG_LEN];
    bit     prev_stall = 1'b0;
    bit     prev_sclr = 1'b1;
    longint prev_out = 0;
    bit     sweep_on = 1'b0;
    longint sweep_min = 100000;
    longint sweep_max = -100000;
    int     zero_seen = 0;

    phase_to_sine dut (
        .CLK          (CLK),
        .SCLR         (SCLR),
        .phase_in     (phase_in),
        .phase_valid  (phase_valid),
        .phase_ready  (phase_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check_value(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic longint golden(input logic [31:0] ph);
        logic [7:0] a;
        longint     m;
        a = ph[29:22];
        if (ph[30]) a = ~a;
        m = longint'(rom_entry(int'(a)));
        return ph[31] ? -m : m;
    endfunction

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic send(input logic [31:0] ph, input longint ev, input bit lat);
        int   guard;
        exp_t e;
        guard       = 0;
        phase_in    = ph;
        phase_valid = 1'b1;
        @(negedge CLK);
        while (!phase_ready && guard < 50) begin
            guard++;
            @(negedge CLK);
        end
        if (guard >= 50) check_value("accept_timeout", guard, 0);
        e.val = ev;
        e.due = cycle + 3;
        e.lat = lat;
        exp_q.push_back(e);
        last_accept = cycle;
        @(posedge CLK);
        #1;
        phase_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 30) begin
            @(posedge CLK);
            g++;
        end
        #1;
        check_value("drain_pending", exp_q.size(), 0);
    endtask

    always @(negedge CLK) begin
        if (cycle < LOG_LEN) sv_log[cycle] = sample_valid;
        if (!SCLR && prev_stall && !prev_sclr) begin
            check_value("hold_valid", sample_valid, 1);
            check_value("hold_data", $signed(sample_out), prev_out);
        end
        if (!SCLR && sample_valid && sample_ready) begin
            $display("cycle %0d: sample %0d", cycle, $signed(sample_out));
            if (exp_q.size() == 0) begin
                check_value("unexpected_sample", $signed(sample_out), 99999);
            end else begin
                mon_e = exp_q.pop_front();
                check_value("sample", $signed(sample_out), mon_e.val);
                if (mon_e.lat) check_value("latency", cycle, mon_e.due);
                if (sweep_on) begin
                    if ($signed(sample_out) < sweep_min) sweep_min = $signed(sample_out);
                    if ($signed(sample_out) > sweep_max) sweep_max = $signed(sample_out);
                    if (sample_out == '0) zero_seen++;
                end
            end
        end
        prev_stall = sample_valid && !sample_ready;
        prev_out   = $signed(sample_out);
        prev_sclr  = SCLR;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bit pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        SCLR         = 1'b1;
        phase_in     = '0;
        phase_valid  = 1'b0;
        sample_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        SCLR = 1'b0;
        @(negedge CLK);
        check_value("reset_valid", sample_valid, 0);
        check_value("reset_out", sample_out, 0);
        check_value("reset_ready", phase_ready, 1);
        @(posedge CLK);
        #1;

        // Quadrant corners back-to-back
        send(32'h0000_0000, 101, 1);
        send(32'h4000_0000, 32767, 1);
        send(32'h8000_0000, -101, 1);
        send(32'hC000_0000, -32767, 1);
        drain();

        // Mirror ends and truncation of the low phase bits
        send(32'h3FFF_FFFF, 32767, 1);
        send(32'h7FFF_FFFF, 101, 1);
        send(32'hFFFF_FFFF, -101, 1);
        send(32'h00FF_FFFF, 704, 1);
        send(32'h00C0_0000, 704, 1);
        drain();

        // Backpressure: 5-cycle downstream stall in the middle of a stream
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(32'(i) * 32'h0010_0000, golden(32'(i) * 32'h0010_0000), 1'b0);
                end
            end
            begin
                repeat (3) @(posedge CLK);
                #1;
                sample_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge CLK);
                    check_value("stall_ready", phase_ready, 0);
                    @(posedge CLK);
                    #1;
                end
                sample_ready = 1'b1;
            end
        join
        drain();

        // Bubbles: valid pattern 1,0,0,1
        send(32'h2000_0000, golden(32'h2000_0000), 1);
        c0 = last_accept;
        repeat (2) @(posedge CLK);
        #1;
        send(32'hA000_0000, golden(32'hA000_0000), 1);
        drain();
        for (int k = 0; k < 4; k++) begin
            check_value("bubble_valid", sv_log[c0 + 3 + k], pat[k]);
        end

        // Reset with a full, stalled pipeline; handshake in the reset cycle is ignored
        sample_ready = 1'b0;
        send(32'h1000_0000, golden(32'h1000_0000), 0);
        send(32'h5000_0000, golden(32'h5000_0000), 0);
        send(32'h9000_0000, golden(32'h9000_0000), 0);
        SCLR         = 1'b1;
        sample_ready = 1'b1;
        phase_in     = 32'h4000_0000;
        phase_valid  = 1'b1;
        exp_q.delete();
        @(posedge CLK);
        #1;
        SCLR        = 1'b0;
        phase_valid = 1'b0;
        @(negedge CLK);
        check_value("flush_valid", sample_valid, 0);
        check_value("flush_out", sample_out, 0);
        check_value("flush_ready", phase_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check_value("flush_quiet", sample_valid, 0);
        end
        @(posedge CLK);
        #1;
        send(32'hC000_0000, -32767, 1);
        drain();

        // Full-turn sweep
        sweep_on = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(32'(i) * 32'h0100_0000, golden(32'(i) * 32'h0100_0000), 1'b1);
        end
        drain();
        sweep_on = 1'b0;
        check_value("sweep_min", sweep_min, -32767);
        check_value("sweep_max", sweep_max, 32767);
        check_value("sweep_zero", zero_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
